mat_stream_reader: RTL and testbench

- Reads a rectangular sub-matrix from a synchronous-read single-port memory and emits its elements as a valid/ready stream.
- It is the producer that feeds the sink side of the team's element FIFOs in the matrix-multiply datapath.
- Walks row-major through n_rows x n_cols elements with a programmable row stride.
- Absorbs the 1-cycle memory read latency with a 2-entry output buffer, so throughput is one element per cycle under no backpressure.

---
 rtl/mat_stream_reader.sv | 203 ++++++++++++++++++++
 tb/tb_mat_stream_reader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mat_stream_reader.sv
// mat_stream_reader: walks an n_rows x n_cols sub-matrix row-major (column-major with MSR_COLMAJOR_EN) into a valid/ready stream.
// First beat 3 cycles after start; m_ready low throttles reads so buffered plus in-flight elements never exceed 2.
module mat_stream_reader #(
    parameter int W  = 16,
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] row_stride,
    input  logic [DW-1:0] n_rows,
    input  logic [DW-1:0] n_cols,
    output logic          busy,
    output logic          done,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [W-1:0]  mem_rdata,
    output logic [W-1:0]  m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FIN
    } state_t;

    localparam logic [DW-1:0] CNT_ONE  = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t state, state_nx;

    logic [AW-1:0] stride_q;
    logic [AW-1:0] line_base;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] inner_n, outer_n;
    logic [DW-1:0] inner_cnt, outer_cnt;
    logic [AW-1:0] inner_step, outer_step;

    logic          inflight, inflight_last;
    logic [1:0]    occ, occ_nx;
    logic [W-1:0]  buf0_data, buf1_data;
    logic          buf0_last, buf1_last;

    logic          push, pop;
    logic          inner_end, outer_end, zero_job;
    logic [2:0]    level;

    // The inner loop walks along a row (or down a column); the outer loop steps the line base.
`ifdef MSR_COLMAJOR_EN
    assign inner_step = stride_q;
    assign outer_step = ADDR_ONE;
`else
    assign inner_step = ADDR_ONE;
    assign outer_step = stride_q;
`endif

    assign push      = inflight;
    assign pop       = (occ != 2'd0) && m_ready;
    assign m_valid   = (occ != 2'd0);
    assign m_data    = buf0_data;
    assign m_last    = buf0_last && m_valid;
    assign mem_addr  = addr_q;

    assign inner_end = (inner_cnt == inner_n - CNT_ONE);
    assign outer_end = (outer_cnt == outer_n - CNT_ONE);
    assign zero_job  = (n_rows == '0) || (n_cols == '0);

    // Committed slots after this cycle, counting the read already on its way back.
    assign level  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign occ_nx = occ + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        mem_rd   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = zero_job ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (level < 3'd2) begin
                    mem_rd = 1'b1;
                    if (inner_end && outer_end) begin
                        state_nx = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (occ_nx == 2'd0) begin
                    state_nx = S_FIN;
                end
            end
            S_FIN: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Address generation and job parameter capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            stride_q      <= '0;
            line_base     <= '0;
            addr_q        <= '0;
            inner_n       <= '0;
            outer_n       <= '0;
            inner_cnt     <= '0;
            outer_cnt     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight <= mem_rd;
            if (state == S_IDLE && start) begin
                stride_q  <= row_stride;
                line_base <= base_addr;
                addr_q    <= base_addr;
                inner_cnt <= '0;
                outer_cnt <= '0;
`ifdef MSR_COLMAJOR_EN
                inner_n   <= n_rows;
                outer_n   <= n_cols;
`else
                inner_n   <= n_cols;
                outer_n   <= n_rows;
`endif
            end else if (mem_rd) begin
                inflight_last <= inner_end;
                if (inner_end) begin
                    inner_cnt <= '0;
                    outer_cnt <= outer_cnt + CNT_ONE;
                    line_base <= line_base + outer_step;
                    addr_q    <= line_base + outer_step;
                end else begin
                    inner_cnt <= inner_cnt + CNT_ONE;
                    addr_q    <= addr_q + inner_step;
                end
            end
        end
    end

    // Two-entry buffer: buf0 is the head and only changes on a pop or when filling an empty buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ       <= 2'd0;
            buf0_data <= '0;
            buf0_last <= 1'b0;
            buf1_data <= '0;
            buf1_last <= 1'b0;
        end else begin
            occ <= occ_nx;
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        buf0_data <= mem_rdata;
                        buf0_last <= inflight_last;
                    end else begin
                        buf1_data <= mem_rdata;
                        buf1_last <= inflight_last;
                    end
                end
                2'b01: begin
                    buf0_data <= buf1_data;
                    buf0_last <= buf1_last;
                end
                2'b11: begin
                    if (occ == 2'd2) begin
                        buf0_data <= buf1_data;
                        buf0_last <= buf1_last;
                        buf1_data <= mem_rdata;
                        buf1_last <= inflight_last;
                    end else begin
                        buf0_data <= mem_rdata;
                        buf0_last <= inflight_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mat_stream_reader.sv
// Directed bench for mat_stream_reader: a scoreboard of expected read addresses and beats is filled at job start.
module tb_mat_stream_reader;
    localparam int W  = 16;
    localparam int AW = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr, row_stride;
    logic [DW-1:0] n_rows, n_cols;
    logic          busy, done, mem_rd;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_rdata = '0;
    logic [W-1:0]  m_data;
    logic          m_valid, m_ready, m_last;

    int tests = 0;
    int fails = 0;
    int rd_cnt = 0;
    int pop_cnt = 0;

    logic [AW-1:0] exp_addr_q[$];
    logic [W:0]    exp_beat_q[$];
    logic          prev_stall = 1'b0;
    logic [W:0]    prev_beat = '0;

    mat_stream_reader #(.W(W), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .base_addr(base_addr), .row_stride(row_stride),
        .n_rows(n_rows), .n_cols(n_cols),
        .busy(busy), .done(done),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    always #5 clk = ~clk;

    // Memory holds its own address as data.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= {{(W-AW){1'b0}}, mem_addr};
    end

    always @(posedge clk) begin
        if (rst) begin
            rd_cnt  <= 0;
            pop_cnt <= 0;
        end else begin
            if (mem_rd) rd_cnt <= rd_cnt + 1;
            if (m_valid && m_ready) pop_cnt <= pop_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd) begin
                check("rd_expected", exp_addr_q.size() != 0, 1);
                if (exp_addr_q.size() != 0) check("rd_addr", mem_addr, exp_addr_q.pop_front());
            end
            if (m_valid && m_ready) begin
                check("beat_expected", exp_beat_q.size() != 0, 1);
                if (exp_beat_q.size() != 0) check("beat_last_data", {m_last, m_data}, exp_beat_q.pop_front());
            end
            if (prev_stall) check("stall_hold", {m_valid, m_last, m_data}, {1'b1, prev_beat});
            if (busy) check("outstanding_le2", (rd_cnt - pop_cnt) <= 2, 1);
            prev_stall = m_valid && !m_ready;
            prev_beat  = {m_last, m_data};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic push_expect(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                               input int nr, input int nc);
        int tmp;
        logic [AW-1:0] a;
`ifdef MSR_COLMAJOR_EN
        for (int c = 0; c < nc; c++) begin
            for (int r = 0; r < nr; r++) begin
                tmp = int'(base) + r * int'(stride) + c;
                a = tmp[AW-1:0];
                exp_addr_q.push_back(a);
                exp_beat_q.push_back({(r == nr - 1), {(W-AW){1'b0}}, a});
            end
        end
`else
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < nc; c++) begin
                tmp = int'(base) + r * int'(stride) + c;
                a = tmp[AW-1:0];
                exp_addr_q.push_back(a);
                exp_beat_q.push_back({(c == nc - 1), {(W-AW){1'b0}}, a});
            end
        end
`endif
    endtask

    // Caller is positioned just after a rising edge; exp_done < 0 skips the exact-timing check.
    task automatic run_job(input string tag, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                           input int nr, input int nc, input bit toggle, input int exp_done);
        int  k = 0;
        int  done_at = -1;
        int  first_rd = -1;
        int  first_vld = -1;
        bit  busy_seen = 1'b0;
        bit  zero = (nr == 0) || (nc == 0);
        push_expect(base, stride, nr, nc);
        base_addr  = base;
        row_stride = stride;
        n_rows     = DW'(nr);
        n_cols     = DW'(nc);
        m_ready    = 1'b1;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        base_addr  = AW'($urandom);
        row_stride = AW'($urandom);
        n_rows     = DW'($urandom);
        n_cols     = DW'($urandom);
        while (done_at < 0 && k < 400) begin
            @(negedge clk);
            k++;
            if (mem_rd && first_rd < 0) first_rd = k;
            if (m_valid && first_vld < 0) first_vld = k;
            if (busy) busy_seen = 1'b1;
            if (done) begin
                done_at = k;
            end else begin
                @(posedge clk);
                #1;
                m_ready = toggle ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            end
        end
        check({tag, "_done_seen"}, done_at > 0, 1);
        if (exp_done > 0) check({tag, "_done_cycle"}, done_at, exp_done);
        check({tag, "_first_rd"}, first_rd, zero ? -1 : 1);
        check({tag, "_first_vld"}, first_vld, zero ? -1 : 3);
        check({tag, "_busy_seen"}, busy_seen, !zero);
        check({tag, "_rd_left"}, exp_addr_q.size(), 0);
        check({tag, "_beats_left"}, exp_beat_q.size(), 0);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(negedge clk);
        check({tag, "_done_pulse"}, {done, busy}, 2'b00);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        row_stride = '0;
        n_rows     = '0;
        n_cols     = '0;
        m_ready    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {busy, done, mem_rd, m_valid, m_last}, 5'b0);
        check("reset_addr", mem_addr, 0);
        check("reset_data", m_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_job("j2x3", 10'h010, 10'd8, 2, 3, 1'b0, 9);
        run_job("j2x3_tog", 10'h010, 10'd8, 2, 3, 1'b1, -1);
        run_job("zero_rows", 10'h020, 10'd4, 0, 5, 1'b0, 1);
        run_job("zero_cols", 10'h020, 10'd4, 3, 0, 1'b0, 1);
        run_job("wrap1x4", 10'h3FE, 10'd1, 1, 4, 1'b0, 7);
        run_job("j3x2_tog", 10'h3F0, 10'h100, 3, 2, 1'b1, -1);
        run_job("j1x1", 10'h077, 10'd3, 1, 1, 1'b0, 4);

        // Reset mid-job while a read is in flight and a beat is buffered.
        push_expect(10'h040, 10'd8, 2, 3);
        base_addr  = 10'h040;
        row_stride = 10'd8;
        n_rows     = 8'd2;
        n_cols     = 8'd3;
        m_ready    = 1'b0;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_addr_q.delete();
        exp_beat_q.delete();
        m_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_idle", {busy, m_valid, mem_rd, done}, 4'b0);
        @(posedge clk);
        #1;
        run_job("after_rst", 10'h055, 10'd1, 1, 1, 1'b0, 4);

`ifdef MSR_COLMAJOR_EN
        run_job("col2x2", 10'h000, 10'd4, 2, 2, 1'b0, 7);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
